// File: rtl/axi_lite_pkg.sv
// Shared AXI4-lite definitions for the block reader slice.
//   AXI_DATA_W / AXI_ADDR_W : bus widths
//   ARPROT_DATA             : protection code for plain data reads
//   reader_state_e          : block reader FSM states
//   word_addr()             : byte address of word idx relative to a word-aligned base
package axi_lite_pkg;

  localparam int unsigned AXI_DATA_W  = 32;
  localparam int unsigned AXI_ADDR_W  = 32;
  localparam logic [2:0]  ARPROT_DATA = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DRAIN
  } reader_state_e;

  // 32-bit wrapping add; the bus has no notion of an address overflow error.
  function automatic logic [AXI_ADDR_W-1:0] word_addr(input logic [AXI_ADDR_W-1:0] base,
                                                      input logic [31:0]            idx);
    return base + {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/axi_lite_block_reader_if.sv
// AXI4-lite read-only channel bundle (AR + R) between the block reader and memory.
//   master : read initiator (drives arvalid/araddr/arprot/rready)
//   slave  : memory responder (drives arready/rvalid/rdata)
interface axi_lite_block_reader_if;
  import axi_lite_pkg::*;

  logic                  mem_axi_arvalid;
  logic                  mem_axi_arready;
  logic [AXI_ADDR_W-1:0] mem_axi_araddr;
  logic [2:0]            mem_axi_arprot;
  logic                  mem_axi_rvalid;
  logic                  mem_axi_rready;
  logic [AXI_DATA_W-1:0] mem_axi_rdata;

  modport master (
    output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot, mem_axi_rready,
    input  mem_axi_arready, mem_axi_rvalid, mem_axi_rdata
  );

  modport slave (
    input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot, mem_axi_rready,
    output mem_axi_arready, mem_axi_rvalid, mem_axi_rdata
  );

endinterface

// File: rtl/axi_lite_block_reader_sync_fifo.sv
// Small synchronous FIFO used as the reader's output buffer.
//   clk, resetn   : clock, asynchronous active-low reset (flushes contents)
//   push, wdata   : write port (ignored when full)
//   pop           : read advance (ignored when empty)
//   rdata         : head entry, valid while !empty
//   full, empty   : occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/axi_lite_block_reader.sv
// AXI4-lite block read initiator.
// Fetches word_len consecutive 32-bit words starting at base_addr, one outstanding
// read at a time, and presents them as a valid/ready stream with a last flag.
//   clk, resetn              : clock, asynchronous active-low reset
//   start, base_addr, word_len : block request (sampled only while busy=0)
//   busy, done               : block in progress / 1-cycle completion pulse
//   mem_axi                  : AR/R channels to the memory responder (master side)
//   out_valid/ready/data/last : output word stream
module axi_lite_block_reader
  import axi_lite_pkg::*;
#(
  parameter int unsigned LEN_W  = 11,
  parameter int unsigned FIFO_D = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [AXI_ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]        word_len,
  output logic                    busy,
  output logic                    done,
  axi_lite_block_reader_if.master mem_axi,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [AXI_DATA_W-1:0]   out_data,
  output logic                    out_last
);

  reader_state_e         state;
  logic [AXI_ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      idx;
  logic                  arvalid_q;
  logic [AXI_ADDR_W-1:0] araddr_q;

  logic                  rready;
  logic                  r_hs;
  logic                  is_last;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [AXI_DATA_W:0]   fifo_rdata;

  assign mem_axi.mem_axi_arvalid = arvalid_q;
  assign mem_axi.mem_axi_araddr  = araddr_q;
  assign mem_axi.mem_axi_arprot  = ARPROT_DATA;
  assign mem_axi.mem_axi_rready  = rready;

  // Only accept a response when the buffer has room, so a full buffer never sees a push.
  assign rready  = (state == DATA) && !fifo_full;
  assign r_hs    = mem_axi.mem_axi_rvalid && rready;
  assign is_last = (idx == len_q - LEN_W'(1));

  sync_fifo #(
    .WIDTH (AXI_DATA_W + 1),
    .DEPTH (FIFO_D)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (r_hs),
    .wdata  ({is_last, mem_axi.mem_axi_rdata}),
    .pop    (out_ready),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_rdata[AXI_DATA_W-1:0];
  assign out_last  = !fifo_empty && fifo_rdata[AXI_DATA_W];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      base_q    <= '0;
      len_q     <= '0;
      idx       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          // busy is still high in the done cycle so a start there is ignored;
          // it drops on the following cycle.
          if (busy) begin
            busy <= 1'b0;
          end else if (start) begin
            if (word_len != '0) begin
              base_q    <= base_addr & ~AXI_ADDR_W'(3);
              len_q     <= word_len;
              idx       <= '0;
              busy      <= 1'b1;
              arvalid_q <= 1'b1;
              araddr_q  <= base_addr & ~AXI_ADDR_W'(3);
              state     <= ADDR;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (mem_axi.mem_axi_arready) begin
            arvalid_q <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (r_hs) begin
            if (is_last) begin
              state <= DRAIN;
            end else begin
              idx       <= idx + LEN_W'(1);
              arvalid_q <= 1'b1;
              araddr_q  <= word_addr(base_q, 32'(idx) + 32'd1);
              state     <= ADDR;
            end
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
